// File: rtl/decim_tx_pkg.sv
// Shared types and constants for the decimated-sample UART transmitter.
package decim_tx_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned BYTES_PER_FRAME   = 3;
  localparam int unsigned BITS_PER_BYTE     = 8;

  // Byte to transmit at a given position within the frame.
  function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                            input logic [15:0] hold,
                                            input logic [7:0]  sync);
    case (idx)
      2'd0:    frame_byte = sync;
      2'd1:    frame_byte = hold[15:8];
      default: frame_byte = hold[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; head word is presented combinationally.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/decim_sample_tx.sv
// Buffers decimated 16-bit samples and sends each as an A5/MSB/LSB UART 8N1 frame.
module decim_sample_tx
  import decim_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [15:0]                   Q,
  input  logic                          Q_VALID,
  input  logic                          OVF_CLR,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          OVF,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LVL
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  tx_state_t   state, state_n;
  logic [CW-1:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  shreg;
  logic [15:0] hold;
  logic        txd_n;
  logic        bit_done;

  logic [15:0] fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop;

  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign bit_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign BUSY     = (state != IDLE);

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (Q_VALID),
    .pop   (fifo_pop),
    .wdata (Q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LVL)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_n = LOAD;
      LOAD:    state_n = START;
      START:   if (bit_done) state_n = DATA;
      DATA:    if (bit_done && bit_cnt == 3'(BITS_PER_BYTE - 1)) state_n = STOP;
      STOP:    if (bit_done) state_n = (byte_idx < 2'(BYTES_PER_FRAME - 1)) ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // TXD is registered, so its next value is derived from the next state and next shift bit.
  always_comb begin
    txd_n = 1'b1;
    if (state_n == START)
      txd_n = 1'b0;
    else if (state_n == DATA)
      txd_n = (state == DATA && bit_done) ? shreg[1] : shreg[0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      TXD      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      hold     <= '0;
    end else begin
      state <= state_n;
      TXD   <= txd_n;
      if (state_n != state || bit_done || state == IDLE || state == LOAD)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      unique case (state)
        IDLE: if (!fifo_empty) hold <= fifo_rdata;
        LOAD: begin
          byte_idx <= '0;
          bit_cnt  <= '0;
          shreg    <= frame_byte(2'd0, hold, SYNC_BYTE);
        end
        DATA: if (bit_done) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        STOP: if (bit_done && state_n == START) begin
          byte_idx <= byte_idx + 2'd1;
          shreg    <= frame_byte(byte_idx + 2'd1, hold, SYNC_BYTE);
        end
        default: ;
      endcase
    end
  end

  // An overflow in the same cycle as a clear takes priority.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      OVF <= 1'b0;
    else if (Q_VALID && fifo_full && !fifo_pop)
      OVF <= 1'b1;
    else if (OVF_CLR)
      OVF <= 1'b0;
  end

endmodule
